// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: uop bundles, sizes, exception codes.
// Also holds small helpers used by the stage and its lane aligner.
package mem_access_stage_pkg;

    localparam int XLEN   = 32;
    localparam int NBYTES = XLEN / 8;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic [3:0] {
        EX_NONE           = 4'd0,
        EX_ILLEGAL        = 4'd2,
        EX_MEM_MISALIGNED = 4'd4
    } ex_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    typedef struct packed {
        logic      isLd;
        logic      isSt;
        mem_size_t size;
        logic      isSigned;
    } mem_op_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] rdVal;
        logic [XLEN-1:0] rs2Val;
        mem_op_t         memOp;
        logic            flagsValid;
        logic [4:0]      flags;
        ex_t             ex;
        logic            exValid;
    } execute_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] rdVal;
        logic            flagsValid;
        logic [4:0]      flags;
        ex_t             ex;
        logic            exValid;
    } memory_t;

    function automatic logic misaligned(mem_size_t s, logic [1:0] a);
        case (s)
            MEM_B:   return 1'b0;
            MEM_H:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic memory_t to_mem(execute_t x);
        memory_t m;
        m.rd         = x.rd;
        m.rdVal      = x.rdVal;
        m.flagsValid = x.flagsValid;
        m.flags      = x.flags;
        m.ex         = x.ex;
        m.exValid    = x.exValid;
        return m;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Pipeline handshake and bypass interfaces shared between stages.
// Modports are named from the point of view of the stage owning the port.
interface pipeline_if;
    logic valid;
    logic stall;
    modport Upstream(input valid, output stall);
    modport Downstream(output valid, input stall);
endinterface

interface bypass_if;
    logic                                  rValid;
    logic [4:0]                            r;
    logic [mem_access_stage_pkg::XLEN-1:0] rVal;
    logic                                  flagsValid;
    logic [4:0]                            flags;
    modport Source(output rValid, r, rVal, flagsValid, flags);
    modport Sink(input rValid, r, rVal, flagsValid, flags);
endinterface

// File: rtl/mem_access_stage_align.sv
// Byte-lane steering: store enables/replicated data, load lane extract/extend.
// Purely combinational; callers guarantee the access is aligned.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]        addr_i,
    input  mem_size_t         size_i,
    input  logic              signed_i,
    input  logic [XLEN-1:0]   sdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [NBYTES-1:0] be_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   ldata_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata_i >> {addr_i, 3'b000};

    always_comb begin
        be_o    = '1;
        wdata_o = sdata_i;
        ldata_o = shifted;
        case (size_i)
            MEM_B: begin
                be_o    = NBYTES'(1) << addr_i;
                wdata_o = {NBYTES{sdata_i[7:0]}};
                ldata_o = {{(XLEN-8){signed_i & shifted[7]}},
                           shifted[7:0]};
            end
            MEM_H: begin
                be_o    = NBYTES'(3) << addr_i;
                wdata_o = {(NBYTES/2){sdata_i[15:0]}};
                ldata_o = {{(XLEN-16){signed_i & shifted[15]}},
                           shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: runs loads/stores on a single-port data bus,
// registers results for writeback and exposes them as a bypass source.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    pipeline_if.Upstream        u,
    pipeline_if.Downstream      d,
    input  execute_t            uopIn,
    output memory_t             uopOut,
    bypass_if.Source            memBypass,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-3:0]     dmem_addr,
    output logic [NBYTES-1:0]   dmem_be,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata
);

    state_t          state_q, state_d;
    execute_t        op_q, op_d;
    memory_t         out_q, out_d;
    logic            dvalid_q, dvalid_d;
    logic            out_stall, accept, is_mem, mis, go_bus, retire;
    memory_t         ret_uop;
    logic [XLEN-1:0] ldata;

    assign out_stall = dvalid_q & d.stall;
    assign u.stall   = (state_q != S_IDLE) | out_stall;
    assign accept    = u.valid & ~u.stall;
    assign is_mem    = (uopIn.memOp.isLd | uopIn.memOp.isSt)
                     & ~uopIn.exValid;
    assign mis       = misaligned(uopIn.memOp.size, uopIn.rdVal[1:0]);
    assign go_bus    = accept & is_mem & ~mis;

    mem_lane_align u_align (
        .addr_i   (op_q.rdVal[1:0]),
        .size_i   (op_q.memOp.size),
        .signed_i (op_q.memOp.isSigned),
        .sdata_i  (op_q.rs2Val),
        .rdata_i  (dmem_rdata),
        .be_o     (dmem_be),
        .wdata_o  (dmem_wdata),
        .ldata_o  (ldata)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go_bus) state_d = S_REQ;
            S_REQ:  if (dmem_gnt)
                        state_d = op_q.memOp.isLd ? S_RESP : S_IDLE;
            S_RESP: if (dmem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_req  = (state_q == S_REQ);
        dmem_we   = dmem_req & op_q.memOp.isSt;
        dmem_addr = op_q.rdVal[XLEN-1:2];
    end

    // Out register is always empty in REQ/RESP, so retires never collide
    always_comb begin
        retire  = 1'b0;
        ret_uop = out_q;
        case (state_q)
            S_IDLE: if (accept && !go_bus) begin
                retire  = 1'b1;
                ret_uop = to_mem(uopIn);
                if (is_mem) begin
                    ret_uop.rd      = '0;
                    ret_uop.ex      = EX_MEM_MISALIGNED;
                    ret_uop.exValid = 1'b1;
                end
            end
            S_REQ: if (dmem_gnt && !op_q.memOp.isLd) begin
                retire     = 1'b1;
                ret_uop    = to_mem(op_q);
                ret_uop.rd = '0;
            end
            S_RESP: if (dmem_rvalid) begin
                retire        = 1'b1;
                ret_uop       = to_mem(op_q);
                ret_uop.rdVal = ldata;
            end
            default: ;
        endcase
    end

    always_comb begin
        dvalid_d = dvalid_q;
        out_d    = out_q;
        op_d     = go_bus ? uopIn : op_q;
        if (!out_stall) begin
            dvalid_d = retire;
            if (retire) out_d = ret_uop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvalid_q <= 1'b0;
            out_q    <= '0;
            op_q     <= '0;
        end else begin
            dvalid_q <= dvalid_d;
            out_q    <= out_d;
            op_q     <= op_d;
        end
    end

    assign d.valid              = dvalid_q;
    assign uopOut               = out_q;
    assign memBypass.rValid     = dvalid_q & (out_q.rd != '0)
                                & ~out_q.exValid;
    assign memBypass.r          = out_q.rd;
    assign memBypass.rVal       = out_q.rdVal;
    assign memBypass.flagsValid = dvalid_q & out_q.flagsValid;
    assign memBypass.flags      = out_q.flags;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: scoreboarded output checks plus a
// configurable single-outstanding memory slave.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    typedef struct {
        memory_t exp;
        bit      chk_rd;
        bit      chk_val;
        bit      exp_byp;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst;
    execute_t          uop_in;
    memory_t           uop_out;
    logic              dmem_req, dmem_we;
    logic [XLEN-3:0]   dmem_addr;
    logic [NBYTES-1:0] dmem_be;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_gnt, dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;

    pipeline_if u_if();
    pipeline_if d_if();
    bypass_if   byp();

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    sb_t  sb[$];
    sb_t  mon_e;

    int          gnt_delay = 0;
    int          rv_delay = 1;
    int          wcnt = 0;
    int          rvcnt = 0;
    int          req_cycles = 0;
    logic [31:0] rd_word = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_access_stage dut (
        .clk         (clk),
        .rst         (rst),
        .u           (u_if),
        .d           (d_if),
        .uopIn       (uop_in),
        .uopOut      (uop_out),
        .memBypass   (byp),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    // Memory slave: grant after gnt_delay req cycles, data rv_delay later
    always @(posedge clk) begin
        #1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (rst) begin
            wcnt  = 0;
            rvcnt = 0;
        end else begin
            if (rvcnt > 0) begin
                rvcnt--;
                if (rvcnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rd_word;
                end
            end
            if (dmem_req) begin
                req_cycles++;
                if (wcnt == gnt_delay) begin
                    dmem_gnt = 1'b1;
                    wcnt     = 0;
                    if (!dmem_we) rvcnt = rv_delay;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && d_if.valid && !d_if.stall) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output rd=%0d val=%h",
                         uop_out.rd, uop_out.rdVal);
            end else begin
                mon_e = sb.pop_front();
                if (uop_out.exValid !== mon_e.exp.exValid ||
                    uop_out.ex !== mon_e.exp.ex ||
                    uop_out.flagsValid !== mon_e.exp.flagsValid ||
                    (mon_e.chk_rd && uop_out.rd !== mon_e.exp.rd) ||
                    (mon_e.chk_val && uop_out.rdVal !== mon_e.exp.rdVal))
                begin
                    errors++;
                    $display("FAIL uop_out got rd=%0d val=%h ex=%0d/%b want rd=%0d val=%h ex=%0d/%b",
                             uop_out.rd, uop_out.rdVal, uop_out.ex,
                             uop_out.exValid, mon_e.exp.rd,
                             mon_e.exp.rdVal, mon_e.exp.ex,
                             mon_e.exp.exValid);
                end
                checks++;
                if (byp.rValid !== mon_e.exp_byp ||
                    (mon_e.exp_byp && (byp.r !== mon_e.exp.rd ||
                     byp.rVal !== mon_e.exp.rdVal)) ||
                    byp.flagsValid !== mon_e.exp.flagsValid) begin
                    errors++;
                    $display("FAIL bypass got v=%b r=%0d val=%h fv=%b want v=%b r=%0d val=%h fv=%b",
                             byp.rValid, byp.r, byp.rVal, byp.flagsValid,
                             mon_e.exp_byp, mon_e.exp.rd, mon_e.exp.rdVal,
                             mon_e.exp.flagsValid);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic execute_t mk(logic [4:0] rd, logic [31:0] v,
                                    logic [31:0] rs2, bit ld, bit st,
                                    mem_size_t sz, bit sgn);
        execute_t x;
        x                = '0;
        x.rd             = rd;
        x.rdVal          = v;
        x.rs2Val         = rs2;
        x.memOp.isLd     = ld;
        x.memOp.isSt     = st;
        x.memOp.size     = sz;
        x.memOp.isSigned = sgn;
        x.ex             = EX_NONE;
        return x;
    endfunction

    function automatic sb_t ex(logic [4:0] rd, logic [31:0] v, bit fv,
                               ex_t e, bit ev, bit crd, bit cval,
                               bit bp);
        sb_t s;
        s.exp            = '0;
        s.exp.rd         = rd;
        s.exp.rdVal      = v;
        s.exp.flagsValid = fv;
        s.exp.ex         = e;
        s.exp.exValid    = ev;
        s.chk_rd         = crd;
        s.chk_val        = cval;
        s.exp_byp        = bp;
        return s;
    endfunction

    task automatic send(input execute_t x);
        int n;
        n      = 0;
        uop_in = x;
        u_if.valid = 1'b1;
        while (u_if.stall === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout stall=%b want 0", u_if.stall);
        end
        @(posedge clk); #1;
        u_if.valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (d_if.valid !== 1'b0 || u_if.stall !== 1'b0 ||
            dmem_req !== 1'b0 || dmem_we !== 1'b0 ||
            byp.rValid !== 1'b0 || byp.flagsValid !== 1'b0) begin
            errors++;
            $display("FAIL reset got dv=%b st=%b req=%b we=%b bv=%b fv=%b want all 0",
                     d_if.valid, u_if.stall, dmem_req, dmem_we,
                     byp.rValid, byp.flagsValid);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        execute_t x;
        int r0;
        r0 = req_cycles;
        x = mk(5'd5, 32'h1234, 32'h0, 0, 0, MEM_W, 0);
        x.flagsValid = 1'b1;
        x.flags = 5'h03;
        sb.push_back(ex(5'd5, 32'h1234, 1, EX_NONE, 0, 1, 1, 1));
        send(x);
        checks++;
        if (d_if.valid !== 1'b1 || byp.rValid !== 1'b1 ||
            byp.r !== 5'd5 || byp.rVal !== 32'h1234) begin
            errors++;
            $display("FAIL alu_latency got dv=%b bv=%b r=%0d val=%h want 1 1 5 1234",
                     d_if.valid, byp.rValid, byp.r, byp.rVal);
        end
        drain();
        checks++;
        if (req_cycles != r0) begin
            errors++;
            $display("FAIL alu_no_req got %0d req cycles want 0",
                     req_cycles - r0);
        end
    endtask

    task automatic test_store_byte();
        gnt_delay = 0;
        sb.push_back(ex(5'd0, 32'h0, 0, EX_NONE, 0, 0, 0, 0));
        send(mk(5'd7, 32'h103, 32'hAB, 0, 1, MEM_B, 0));
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 ||
            dmem_be !== 4'b1000 || dmem_wdata !== 32'hABABABAB ||
            dmem_addr !== 30'h40 || u_if.stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_bus got req=%b we=%b be=%b wd=%h a=%h want 1 1 1000 abababab 40",
                     dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (d_if.valid !== 1'b1 || byp.rValid !== 1'b0 ||
            dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL sb_retire got dv=%b bv=%b req=%b want 1 0 0",
                     d_if.valid, byp.rValid, dmem_req);
        end
        drain();
    endtask

    task automatic test_load_half();
        int n;
        gnt_delay = 0;
        rv_delay  = 2;
        rd_word   = 32'h8001_0000;
        sb.push_back(ex(5'd9, 32'hFFFF8001, 0, EX_NONE, 0, 1, 1, 1));
        send(mk(5'd9, 32'h102, 32'h0, 1, 0, MEM_H, 1));
        n = 0;
        while (d_if.valid !== 1'b1 && n < 20) begin
            checks++;
            if (u_if.stall !== 1'b1) begin
                errors++;
                $display("FAIL lh_stall got %b want 1 at cycle %0d",
                         u_if.stall, n);
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL lh_latency got %0d want 3", n);
        end
        drain();
    endtask

    task automatic test_misaligned();
        int r0;
        r0 = req_cycles;
        sb.push_back(ex(5'd0, 32'h0, 0, EX_MEM_MISALIGNED, 1, 1, 0, 0));
        send(mk(5'd6, 32'h101, 32'h0, 1, 0, MEM_W, 0));
        checks++;
        if (d_if.valid !== 1'b1 || dmem_req !== 1'b0 ||
            byp.rValid !== 1'b0 || uop_out.exValid !== 1'b1) begin
            errors++;
            $display("FAIL lw_mis got dv=%b req=%b bv=%b exv=%b want 1 0 0 1",
                     d_if.valid, dmem_req, byp.rValid, uop_out.exValid);
        end
        drain();
        sb.push_back(ex(5'd0, 32'h0, 0, EX_MEM_MISALIGNED, 1, 1, 0, 0));
        send(mk(5'd8, 32'h23, 32'h55, 0, 1, MEM_H, 0));
        drain();
        checks++;
        if (req_cycles != r0) begin
            errors++;
            $display("FAIL mis_no_req got %0d want 0", req_cycles - r0);
        end
    endtask

    task automatic test_exc_passthrough();
        execute_t x;
        int r0;
        r0 = req_cycles;
        x = mk(5'd4, 32'h55, 32'h0, 1, 0, MEM_W, 0);
        x.ex = EX_ILLEGAL;
        x.exValid = 1'b1;
        sb.push_back(ex(5'd4, 32'h55, 0, EX_ILLEGAL, 1, 1, 1, 0));
        send(x);
        drain();
        checks++;
        if (req_cycles != r0) begin
            errors++;
            $display("FAIL exc_no_req got %0d want 0", req_cycles - r0);
        end
    endtask

    task automatic test_lbu_stalls();
        int n, r0;
        r0 = req_cycles;
        gnt_delay = 3;
        rv_delay  = 1;
        rd_word   = 32'h1234_56F5;
        d_if.stall = 1'b1;
        sb.push_back(ex(5'd10, 32'hF5, 0, EX_NONE, 0, 1, 1, 1));
        send(mk(5'd10, 32'h0, 32'h0, 1, 0, MEM_B, 0));
        n = 0;
        while (d_if.valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (d_if.valid !== 1'b1 || uop_out.rdVal !== 32'hF5 ||
                u_if.stall !== 1'b1) begin
                errors++;
                $display("FAIL lbu_hold got dv=%b val=%h st=%b want 1 f5 1",
                         d_if.valid, uop_out.rdVal, u_if.stall);
            end
        end
        d_if.stall = 1'b0;
        drain();
        checks++;
        if (req_cycles - r0 != 4) begin
            errors++;
            $display("FAIL lbu_req_held got %0d want 4", req_cycles - r0);
        end
        gnt_delay = 0;
    endtask

    task automatic test_back_to_back();
        int c0;
        gnt_delay = 0;
        rv_delay  = 1;
        rd_word   = 32'hDEAD_BEEF;
        sb.push_back(ex(5'd11, 32'hDEADBEEF, 0, EX_NONE, 0, 1, 1, 1));
        send(mk(5'd11, 32'h10, 32'h0, 1, 0, MEM_W, 0));
        c0 = cyc;
        sb.push_back(ex(5'd12, 32'hFFFFFFDE, 0, EX_NONE, 0, 1, 1, 1));
        send(mk(5'd12, 32'h13, 32'h0, 1, 0, MEM_B, 1));
        checks++;
        if (cyc - c0 != 3) begin
            errors++;
            $display("FAIL ld_throughput got %0d want 3", cyc - c0);
        end
        sb.push_back(ex(5'd0, 32'h0, 0, EX_NONE, 0, 0, 0, 0));
        send(mk(5'd3, 32'h22, 32'h1234_5678, 0, 1, MEM_H, 0));
        checks++;
        if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h56785678 ||
            dmem_addr !== 30'h8 || dmem_we !== 1'b1) begin
            errors++;
            $display("FAIL sh_bus got be=%b wd=%h a=%h we=%b want 1100 56785678 8 1",
                     dmem_be, dmem_wdata, dmem_addr, dmem_we);
        end
        sb.push_back(ex(5'd13, 32'h99, 0, EX_NONE, 0, 1, 1, 1));
        send(mk(5'd13, 32'h99, 32'h0, 0, 0, MEM_W, 0));
        drain();
    endtask

    task automatic test_reset_mid();
        gnt_delay = 0;
        rv_delay  = 10;
        send(mk(5'd14, 32'h200, 32'h0, 1, 0, MEM_W, 0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b0 || d_if.valid !== 1'b0 ||
            u_if.stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got req=%b dv=%b st=%b want 0 0 0",
                     dmem_req, d_if.valid, u_if.stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rv_delay = 1;
        sb.push_back(ex(5'd15, 32'h77, 0, EX_NONE, 0, 1, 1, 1));
        send(mk(5'd15, 32'h77, 32'h0, 0, 0, MEM_W, 0));
        checks++;
        if (d_if.valid !== 1'b1 || byp.r !== 5'd15) begin
            errors++;
            $display("FAIL post_rst_alu got dv=%b r=%0d want 1 15",
                     d_if.valid, byp.r);
        end
        drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        u_if.valid  = 1'b0;
        d_if.stall  = 1'b0;
        uop_in      = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        rst         = 1'b1;
        test_reset();
        test_alu();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_exc_passthrough();
        test_lbu_stalls();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
